apb_spi_csr_fifo: RTL and testbench

APB3 slave register block for the SPI master, the parametrised successor of the single-frame APB front end. Software-written SPI frames are queued in a TX FIFO toward the SPI transmitter, and received words are queued in an RX FIFO. It also provides a status register, an interrupt controller, APB wait states on TX back-pressure, and PSLVERR on illegal accesses. It sits between the APB interconnect and the spi_tx/spi_rx datapath.

---
 rtl/apb_spi_csr_fifo.sv | 183 ++++++++++++++++++
 tb/tb_apb_spi_csr_fifo.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_spi_csr_fifo.sv
// APB3 register block for the SPI master: CSRs, TX/RX frame FIFOs, status,
// interrupt controller, wait states on TX back-pressure and PSLVERR decode.
module apb_spi_csr_fifo #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned TXF_DEPTH  = 4,
   parameter int unsigned RXF_DEPTH  = 4,
   parameter logic [7:0]  CLKDIV_RST = 8'd4
) (
   input  logic              pclk_i,
   input  logic              prstn_i,
   input  logic [ADDR_W-1:0] paddr_i,
   input  logic              psel_i,
   input  logic              penable_i,
   input  logic              pwrite_i,
   input  logic [31:0]       pwdata_i,
   output logic [31:0]       prdata_o,
   output logic              pready_o,
   output logic              pslverr_o,
   output logic [31:0]       tx_data_o,
   output logic              tx_vld_o,
   input  logic              tx_rdy_i,
   input  logic [31:0]       rx_data_i,
   input  logic              rx_vld_i,
   input  logic              eot_i,
   output logic [7:0]        spi_clk_div_o,
   output logic              irq_o
);

   localparam int unsigned TXA_W = $clog2(TXF_DEPTH);
   localparam int unsigned TXP_W = TXA_W + 1;
   localparam int unsigned RXA_W = $clog2(RXF_DEPTH);
   localparam int unsigned RXP_W = RXA_W + 1;

   localparam logic [2:0] A_CMD    = 3'd0;
   localparam logic [2:0] A_ADDR   = 3'd1;
   localparam logic [2:0] A_LEN    = 3'd2;
   localparam logic [2:0] A_TXPUSH = 3'd3;
   localparam logic [2:0] A_RXPOP  = 3'd4;
   localparam logic [2:0] A_CTRL   = 3'd5;
   localparam logic [2:0] A_STATUS = 3'd6;
   localparam logic [2:0] A_INT    = 3'd7;

   logic [3:0] cmd_q;
   logic [3:0] addr_q;
   logic [7:0] len_q;
   logic       tx_en_q;
   logic [7:0] clkdiv_q;
   logic [2:0] ie_q;
   logic [1:0] int_q;
   logic       irq_q;

   logic [31:0]      tx_mem [TXF_DEPTH];
   logic [TXP_W-1:0] tx_wptr, tx_rptr, tx_level;
   logic             tx_full, tx_empty, tx_push, tx_pop;

   logic [31:0]      rx_mem [RXF_DEPTH];
   logic [RXP_W-1:0] rx_wptr, rx_rptr, rx_level;
   logic             rx_full, rx_empty, rx_push, rx_pop, rx_ovf;

   logic [2:0]  sel;
   logic        access, addr_bad, err, stall, wr_ok, rd_ok;
   logic [1:0]  int_clr;
   logic [31:0] status, rdata, frame;
   logic        unused_pwdata;

   // Bits of the write bus that no register field or frame uses.
   assign unused_pwdata = ^pwdata_i[31:19];

   // Address decode and access qualification
   assign sel      = paddr_i[4:2];
   assign access   = psel_i & penable_i;
   assign addr_bad = ((paddr_i >> 5) != '0) | (paddr_i[1:0] != 2'b00);
   assign err      = access & (addr_bad
                   | (pwrite_i & ((sel == A_STATUS) | (sel == A_RXPOP)))
                   | (!pwrite_i & (sel == A_RXPOP) & rx_empty));
   assign stall    = access & pwrite_i & !addr_bad & (sel == A_TXPUSH) & tx_full;
   assign wr_ok    = access & pwrite_i & !stall & !err;
   assign rd_ok    = access & !pwrite_i & !err;

   assign pready_o  = !stall;
   assign pslverr_o = err;

   assign frame   = {cmd_q, addr_q, len_q, pwdata_i[15:0]};
   assign tx_push = wr_ok & (sel == A_TXPUSH);
   assign tx_pop  = tx_vld_o & tx_rdy_i;
   assign rx_pop  = rd_ok & (sel == A_RXPOP);
   assign rx_push = rx_vld_i & (!rx_full | rx_pop);
   assign rx_ovf  = rx_vld_i & rx_full & !rx_pop;
   assign int_clr = (wr_ok && (sel == A_INT)) ? pwdata_i[1:0] : 2'b00;

   assign tx_level = tx_wptr - tx_rptr;
   assign tx_full  = (tx_level == TXP_W'(TXF_DEPTH));
   assign tx_empty = (tx_level == '0);
   assign rx_level = rx_wptr - rx_rptr;
   assign rx_full  = (rx_level == RXP_W'(RXF_DEPTH));
   assign rx_empty = (rx_level == '0);

   assign tx_vld_o      = tx_en_q & !tx_empty;
   assign tx_data_o     = tx_mem[tx_rptr[TXA_W-1:0]];
   assign spi_clk_div_o = clkdiv_q;
   assign irq_o         = irq_q;

   // CSRs, interrupt pending bits and the registered interrupt line
   always_ff @(posedge pclk_i or negedge prstn_i) begin
      if (!prstn_i) begin
         cmd_q    <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         tx_en_q  <= 1'b0;
         clkdiv_q <= CLKDIV_RST;
         ie_q     <= '0;
         int_q    <= '0;
         irq_q    <= 1'b0;
      end else begin
         if (wr_ok) begin
            case (sel)
               A_CMD:   cmd_q  <= pwdata_i[3:0];
               A_ADDR:  addr_q <= pwdata_i[3:0];
               A_LEN:   len_q  <= pwdata_i[7:0];
               A_CTRL: begin
                  tx_en_q  <= pwdata_i[0];
                  clkdiv_q <= pwdata_i[15:8];
                  ie_q     <= pwdata_i[18:16];
               end
               default: ;
            endcase
         end
         int_q[0] <= eot_i  | (int_q[0] & !int_clr[0]);
         int_q[1] <= rx_ovf | (int_q[1] & !int_clr[1]);
         irq_q    <= (int_q[0] & ie_q[0]) | (!rx_empty & ie_q[1]) | (int_q[1] & ie_q[2]);
      end
   end

   // FIFO pointers carry a wrap bit so full and empty are distinguishable
   always_ff @(posedge pclk_i or negedge prstn_i) begin
      if (!prstn_i) begin
         tx_wptr <= '0;
         tx_rptr <= '0;
         rx_wptr <= '0;
         rx_rptr <= '0;
      end else begin
         if (tx_push) tx_wptr <= tx_wptr + TXP_W'(1);
         if (tx_pop)  tx_rptr <= tx_rptr + TXP_W'(1);
         if (rx_push) rx_wptr <= rx_wptr + RXP_W'(1);
         if (rx_pop)  rx_rptr <= rx_rptr + RXP_W'(1);
      end
   end

   always_ff @(posedge pclk_i) begin
      if (tx_push) tx_mem[tx_wptr[TXA_W-1:0]] <= frame;
      if (rx_push) rx_mem[rx_wptr[RXA_W-1:0]] <= rx_data_i;
   end

   always_comb begin
      status        = '0;
      status[6:0]   = 7'(tx_level);
      status[14:8]  = 7'(rx_level);
      status[16]    = tx_full;
      status[17]    = tx_empty;
      status[18]    = rx_full;
      status[19]    = rx_empty;
   end

   // Read mux; zero outside a successful read access
   always_comb begin
      rdata = '0;
      if (rd_ok) begin
         case (sel)
            A_CMD:    rdata = {28'd0, cmd_q};
            A_ADDR:   rdata = {28'd0, addr_q};
            A_LEN:    rdata = {24'd0, len_q};
            A_RXPOP:  rdata = rx_mem[rx_rptr[RXA_W-1:0]];
            A_CTRL:   rdata = {13'd0, ie_q, clkdiv_q, 7'd0, tx_en_q};
            A_STATUS: rdata = status;
            A_INT:    rdata = {30'd0, int_q};
            default:  rdata = '0;
         endcase
      end
   end

   assign prdata_o = rdata;

endmodule

// File: tb/tb_apb_spi_csr_fifo.sv
// Directed bench for apb_spi_csr_fifo: table of register accesses followed by
// hand-written TX stall, RX overflow, interrupt and reset sequences.
module tb_apb_spi_csr_fifo;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  paddr;
   logic        psel, penable, pwrite;
   logic [31:0] pwdata, prdata;
   logic        pready, pslverr;
   logic [31:0] tx_data;
   logic        tx_vld, tx_rdy;
   logic [31:0] rx_data;
   logic        rx_vld, eot;
   logic [7:0]  div;
   logic        irq;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   apb_spi_csr_fifo #(
      .ADDR_W(8), .TXF_DEPTH(4), .RXF_DEPTH(4), .CLKDIV_RST(8'd4)
   ) dut (
      .pclk_i(clk), .prstn_i(rstn), .paddr_i(paddr), .psel_i(psel),
      .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata),
      .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
      .tx_data_o(tx_data), .tx_vld_o(tx_vld), .tx_rdy_i(tx_rdy),
      .rx_data_i(rx_data), .rx_vld_i(rx_vld), .eot_i(eot),
      .spi_clk_div_o(div), .irq_o(irq)
   );

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      logic        exp_err;
      logic [7:0]  exp_div;
   } vec_t;

   vec_t tbl [25];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!pready && n < 16) begin
         @(posedge clk); #1;
         n++;
      end
      if (!pready) begin
         n_total++;
         $display("FAIL pready_timeout: got 0 expected 1");
      end
   endtask

   // Each APB task starts and ends 1 time unit after a rising edge.
   task automatic apb_write(input logic [7:0] a, input logic [31:0] wd, output logic e);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = wd;
      @(posedge clk); #1;
      penable = 1'b1; #1;
      wait_ready();
      e = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(posedge clk); #1;
      penable = 1'b1; #1;
      wait_ready();
      d = prdata; e = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic        e;
      logic [31:0] heads [16];
      int          nh;

      tbl[0]  = '{1'b0, 8'h14, 32'h0,         32'h0000_0400, 1'b0, 8'h04};
      tbl[1]  = '{1'b0, 8'h18, 32'h0,         32'h000A_0000, 1'b0, 8'h04};
      tbl[2]  = '{1'b0, 8'h00, 32'h0,         32'h0,         1'b0, 8'h04};
      tbl[3]  = '{1'b1, 8'h00, 32'hFFFF_FFF3, 32'h0,         1'b0, 8'h04};
      tbl[4]  = '{1'b0, 8'h00, 32'h0,         32'h3,         1'b0, 8'h04};
      tbl[5]  = '{1'b1, 8'h04, 32'h15,        32'h0,         1'b0, 8'h04};
      tbl[6]  = '{1'b0, 8'h04, 32'h0,         32'h5,         1'b0, 8'h04};
      tbl[7]  = '{1'b1, 8'h08, 32'h110,       32'h0,         1'b0, 8'h04};
      tbl[8]  = '{1'b0, 8'h08, 32'h0,         32'h10,        1'b0, 8'h04};
      tbl[9]  = '{1'b1, 8'h14, 32'hFFFF_FFFF, 32'h0,         1'b0, 8'hFF};
      tbl[10] = '{1'b0, 8'h14, 32'h0,         32'h0007_FF01, 1'b0, 8'hFF};
      tbl[11] = '{1'b1, 8'h14, 32'h0000_0401, 32'h0,         1'b0, 8'h04};
      tbl[12] = '{1'b0, 8'h14, 32'h0,         32'h0000_0401, 1'b0, 8'h04};
      tbl[13] = '{1'b1, 8'h18, 32'h1234,      32'h0,         1'b1, 8'h04};
      tbl[14] = '{1'b0, 8'h18, 32'h0,         32'h000A_0000, 1'b0, 8'h04};
      tbl[15] = '{1'b1, 8'h10, 32'h1,         32'h0,         1'b1, 8'h04};
      tbl[16] = '{1'b0, 8'h10, 32'h0,         32'h0,         1'b1, 8'h04};
      tbl[17] = '{1'b0, 8'h20, 32'h0,         32'h0,         1'b1, 8'h04};
      tbl[18] = '{1'b0, 8'h02, 32'h0,         32'h0,         1'b1, 8'h04};
      tbl[19] = '{1'b1, 8'h40, 32'h7,         32'h0,         1'b1, 8'h04};
      tbl[20] = '{1'b0, 8'h00, 32'h0,         32'h3,         1'b0, 8'h04};
      tbl[21] = '{1'b0, 8'h0C, 32'h0,         32'h0,         1'b0, 8'h04};
      tbl[22] = '{1'b0, 8'h1C, 32'h0,         32'h0,         1'b0, 8'h04};
      tbl[23] = '{1'b1, 8'h01, 32'h9,         32'h0,         1'b1, 8'h04};
      tbl[24] = '{1'b0, 8'h00, 32'h0,         32'h3,         1'b0, 8'h04};

      rstn = 1'b0; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      pwdata = '0; tx_rdy = 1'b0; rx_data = '0; rx_vld = 1'b0; eot = 1'b0;
      #22 rstn = 1'b1;
      @(posedge clk); #1;

      chk("rst_div",    32'(div),    32'd4);
      chk("rst_irq",    32'(irq),    32'd0);
      chk("rst_txvld",  32'(tx_vld), 32'd0);
      chk("rst_pready", 32'(pready), 32'd1);

      // Register map, masking and error decode
      for (int i = 0; i < 25; i++) begin
         if (tbl[i].wr) begin
            apb_write(tbl[i].addr, tbl[i].wdata, e);
         end else begin
            apb_read(tbl[i].addr, d, e);
            chk($sformatf("vec%0d_rdata", i), d, tbl[i].exp_data);
         end
         chk($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
         chk($sformatf("vec%0d_div", i), 32'(div), 32'(tbl[i].exp_div));
      end

      // Single frame to a ready transmitter
      tx_rdy = 1'b1;
      apb_write(8'h0C, 32'h0000_BEEF, e);
      chk("push_vld",  32'(tx_vld), 32'd1);
      chk("push_data", tx_data,     32'h3510_BEEF);
      @(posedge clk); #1;
      chk("push_vld_gone", 32'(tx_vld), 32'd0);

      // Fill TX with the transmitter stalled, then stall a fifth push
      tx_rdy = 1'b0;
      for (int i = 1; i <= 4; i++) apb_write(8'h0C, 32'(i), e);
      apb_read(8'h18, d, e);
      chk("status_txfull", d, 32'h0009_0004);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h5;
      @(posedge clk); #1;
      penable = 1'b1; #1;
      chk("stall_pready0", 32'(pready), 32'd0);
      @(posedge clk); #1;
      chk("stall_pready1", 32'(pready), 32'd0);
      nh = 0;
      if (tx_vld) begin heads[nh] = tx_data; nh++; end
      tx_rdy = 1'b1; #1;
      chk("stall_full_pop_cycle", 32'(pready), 32'd0);
      @(posedge clk); #1;
      chk("stall_release", 32'(pready), 32'd1);
      if (tx_vld) begin heads[nh] = tx_data; nh++; end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      if (tx_vld) begin heads[nh] = tx_data; nh++; end
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (tx_vld && nh < 16) begin heads[nh] = tx_data; nh++; end
      end
      chk("tx_frame_count", 32'(nh), 32'd5);
      for (int i = 0; i < 5 && i < nh; i++)
         chk($sformatf("tx_order%0d", i), heads[i], {16'h3510, 16'(i + 1)});

      // RX overflow with OVF interrupt enabled
      apb_write(8'h14, 32'h0004_0401, e);
      for (int i = 0; i < 5; i++) begin
         rx_data = 32'hA0 + 32'(i); rx_vld = 1'b1;
         @(posedge clk); #1;
      end
      rx_vld = 1'b0;
      apb_read(8'h1C, d, e);
      chk("int_ovf", d, 32'h2);
      chk("irq_ovf", 32'(irq), 32'd1);
      apb_read(8'h18, d, e);
      chk("status_rxfull", d, 32'h0006_0400);
      for (int i = 0; i < 4; i++) begin
         apb_read(8'h10, d, e);
         chk($sformatf("rxpop%0d", i), d, 32'hA0 + 32'(i));
         chk($sformatf("rxpop%0d_err", i), 32'(e), 32'd0);
      end
      apb_read(8'h10, d, e);
      chk("rxpop_empty_err",  32'(e), 32'd1);
      chk("rxpop_empty_data", d,      32'd0);
      apb_write(8'h1C, 32'h2, e);
      apb_read(8'h1C, d, e);
      chk("int_ovf_cleared", d, 32'h0);
      chk("irq_ovf_cleared", 32'(irq), 32'd0);

      // Pop and push in the same cycle on a full RX FIFO
      for (int i = 0; i < 4; i++) begin
         rx_data = 32'hB0 + 32'(i); rx_vld = 1'b1;
         @(posedge clk); #1;
      end
      rx_vld = 1'b0;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h10;
      @(posedge clk); #1;
      penable = 1'b1; rx_vld = 1'b1; rx_data = 32'hB4; #1;
      d = prdata; e = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; rx_vld = 1'b0;
      chk("samecyc_data", d, 32'hB0);
      chk("samecyc_err",  32'(e), 32'd0);
      apb_read(8'h1C, d, e);
      chk("samecyc_no_ovf", d, 32'h0);
      apb_read(8'h18, d, e);
      chk("samecyc_level", d, 32'h0006_0400);
      for (int i = 1; i <= 4; i++) begin
         apb_read(8'h10, d, e);
         chk($sformatf("samecyc_pop%0d", i), d, 32'hB0 + 32'(i));
      end

      // EOT interrupt; set beats a simultaneous W1C
      apb_write(8'h14, 32'h0001_0401, e);
      eot = 1'b1;
      @(posedge clk); #1;
      eot = 1'b0;
      @(posedge clk); #1;
      chk("irq_eot", 32'(irq), 32'd1);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h1C; pwdata = 32'h1;
      @(posedge clk); #1;
      penable = 1'b1; eot = 1'b1; #1;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; eot = 1'b0;
      apb_read(8'h1C, d, e);
      chk("int_set_wins", d, 32'h1);
      apb_write(8'h1C, 32'h1, e);
      apb_read(8'h1C, d, e);
      chk("int_eot_cleared", d, 32'h0);
      @(posedge clk); #1;
      chk("irq_eot_cleared", 32'(irq), 32'd0);

      // Asynchronous reset during a stalled push
      tx_rdy = 1'b0;
      for (int i = 0; i < 4; i++) apb_write(8'h0C, 32'h100 + 32'(i), e);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h1FF;
      @(posedge clk); #1;
      penable = 1'b1; #1;
      chk("rst_stall_before", 32'(pready), 32'd0);
      rstn = 1'b0; #1;
      chk("rst_stall_pready", 32'(pready), 32'd1);
      chk("rst_stall_txvld",  32'(tx_vld), 32'd0);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      apb_read(8'h18, d, e);
      chk("rst_status", d, 32'h000A_0000);
      apb_read(8'h14, d, e);
      chk("rst_ctrl", d, 32'h0000_0400);
      chk("rst_irq2", 32'(irq), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
